r_cpu_mc: RTL
=============

# r_cpu_mc

Parametrised multi-cycle successor to the single-cycle R-type CPU: executes MIPS R-format instructions from an internal instruction memory through a FETCH/DECODE/EXEC/WB state machine, with configurable datapath width and memory depth. Adds an instruction-load port, illegal-instruction halt, and a retired-instruction counter. Exposes the same debug outputs as the single-cycle core so one bench style covers both.

## Interface
- DATA_W, 32, register/ALU width; legal values 16, 32 or 64
- IMEM_DEPTH, 64, instruction words; power of 2; AW = log2(IMEM_DEPTH)
- REG_INIT_IDX, 1, 1: register i resets to i; 0: all registers reset to 0
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  synchronous, active-high reset
- imem_we  in  1  instruction-memory write enable; honoured only while rst=1
- imem_addr  in  AW  instruction word address
- imem_wdata  in  32  instruction word
- Inst_code  out  32  instruction register (IR)
- PC  out  32  byte address of the current instruction
- opcode, rs, rt, rd, shamt, func  out  6/5/5/5/5/6  IR fields
- ALU_OP  out  3  decoded operation
- rs_shamt  out  1  1 selects zero-extended shamt as the ALU A operand
- ALU_A  out  DATA_W  ALU A operand after the rs_shamt mux
- ALU_F  out  DATA_W  registered ALU result
- FR_ZF, FR_OF  out  1  flag register
- state  out  3  FETCH=0, DECODE=1, EXEC=2, WB=3, HALT=4
- halted  out  1  state==HALT
- instret  out  32  retired-instruction count

## Operation
- Decode (opcode must be 0): func 0x20 add ALU_OP=100; 0x22 sub 101; 0x24 and 000; 0x25 or 001; 0x26 xor 010; 0x27 nor 011; 0x2A slt 110; 0x00 sll 111 with rs_shamt=1; 0x04 sllv 111 with rs_shamt=0. Any other opcode/func is illegal.
- Shifts: F = B << (A[log2(DATA_W)-1:0]). A = rs register, or shamt zero-extended when rs_shamt=1.
- slt: signed compare; F = 1 or 0.
- Arithmetic wraps modulo 2^DATA_W. FR_OF = signed overflow for add/sub, 0 for all other ops. FR_ZF = (F==0) for every op.
- Register file: 32 x DATA_W, two read ports, one write port. r0 reads 0 always; writes to r0 are discarded.
- FETCH: IR <= imem[PC[AW+1:2]]; go to DECODE.
- DECODE: A <= reg[rs], B <= reg[rt], ALU_OP/rs_shamt registered. Illegal -> HALT, else EXEC.
- EXEC: ALU_F and flags updated; go to WB.
- WB: reg[rd] <= ALU_F; PC <= PC+4, wrapping at IMEM_DEPTH*4 to 0; instret++; go to FETCH.
- HALT: absorbing until rst. PC, IR, registers and flags are frozen; PC points at the illegal instruction; instret excludes it.
- Reset: state=FETCH; PC=0; IR=0; ALU_F=0; FR_ZF=0; FR_OF=0; ALU_OP=000; rs_shamt=0; instret=0; registers per REG_INIT_IDX; halted=0. Derived outputs (fields, ALU_A) follow from these values.
- imem contents are not reset. imem writes while rst=1 take effect at that edge.
- Reset asserted mid-instruction aborts that instruction with no register write. imem_we while rst=0 is ignored.

## Timing
- 4 cycles per instruction. The first FETCH edge is the first rising edge with rst=0.
- The register write, PC and instret updates for instruction n occur on edge 4n+4 after reset release.
- Result forwarding is not needed: WB completes before the next DECODE reads.
- HALT is entered on the DECODE edge, 2 cycles after the illegal instruction is fetched.
- PC wrap: last word at (IMEM_DEPTH-1)*4 -> next PC is 0 with no extra cycle.

## Test plan
- Load 0x00221820 (add $3,$1,$2), REG_INIT_IDX=1 -> after 4 cycles: r3=3, ALU_F=3, ZF=0, OF=0, PC=4, instret=1.
- Load 0x00002027, 0x00042FC0, 0x00A53020 (nor $4,$0,$0; sll $5,$4,31; add $6,$5,$5) -> r4=0xFFFFFFFF, r5=0x80000000, r6=0, final ZF=1, OF=1; during sll rs_shamt=1, ALU_A=31.
- Load 0x00220020 (add $0,$1,$2) -> ALU_F=3, r0 still reads 0, instret=1.
- Load 0x20000000 at word 1 -> halted=1 at cycle 6, PC=4, instret=1; unchanged after 20 more cycles; rst clears it and execution restarts at PC=0.
- IMEM_DEPTH=4, all words 0 (sll $0,$0,0) -> PC sequence 0,4,8,12,0; ZF=1 each EXEC; instret=5 after 20 cycles.
- Assert rst during the EXEC of add $3,$1,$2 -> r3 stays 3 (reset value), PC=0, instret=0; imem contents preserved.

Source files
------------

// File: rtl/r_cpu_mc.sv
// r_cpu_mc: multi-cycle MIPS R-type core (FETCH/DECODE/EXEC/WB) with a loadable
// instruction memory, illegal-instruction halt and a retired-instruction counter.
module r_cpu_mc #(
    parameter int DATA_W       = 32,
    parameter int IMEM_DEPTH   = 64,
    parameter int REG_INIT_IDX = 1,
    localparam int AW          = $clog2(IMEM_DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              imem_we,
    input  logic [AW-1:0]     imem_addr,
    input  logic [31:0]       imem_wdata,
    output logic [31:0]       Inst_code,
    output logic [31:0]       PC,
    output logic [5:0]        opcode,
    output logic [4:0]        rs,
    output logic [4:0]        rt,
    output logic [4:0]        rd,
    output logic [4:0]        shamt,
    output logic [5:0]        func,
    output logic [2:0]        ALU_OP,
    output logic              rs_shamt,
    output logic [DATA_W-1:0] ALU_A,
    output logic [DATA_W-1:0] ALU_F,
    output logic              FR_ZF,
    output logic              FR_OF,
    output logic [2:0]        state,
    output logic              halted,
    output logic [31:0]       instret
);
    localparam int SW = $clog2(DATA_W);
    localparam int M  = DATA_W - 1;

    typedef enum logic [2:0] {FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, WB = 3'd3, HALT = 3'd4} state_t;

    state_t            state_q, state_d;
    logic [31:0]       imem [IMEM_DEPTH];
    logic [DATA_W-1:0] regs_q [32];
    logic [AW-1:0]     pc_q;
    logic [31:0]       ir_q, instret_q;
    logic [DATA_W-1:0] a_q, b_q, f_q, f_d, sum;
    logic [2:0]        op_q, op_d;
    logic              sh_q, sh_d, legal, zf_q, of_q, of_d;

    always_comb begin
        op_d  = 3'b000;
        sh_d  = 1'b0;
        legal = ir_q[31:26] == 6'd0;
        case (ir_q[5:0])
            6'h20: op_d = 3'b100;
            6'h22: op_d = 3'b101;
            6'h24: op_d = 3'b000;
            6'h25: op_d = 3'b001;
            6'h26: op_d = 3'b010;
            6'h27: op_d = 3'b011;
            6'h2A: op_d = 3'b110;
            6'h00: begin op_d = 3'b111; sh_d = 1'b1; end
            6'h04: op_d = 3'b111;
            default: legal = 1'b0;
        endcase
    end

    assign ALU_A = sh_q ? DATA_W'(ir_q[10:6]) : a_q;

    // add and sub share one adder; op_q[0] selects subtraction
    always_comb begin
        sum  = op_q[0] ? ALU_A - b_q : ALU_A + b_q;
        f_d  = '0;
        of_d = 1'b0;
        case (op_q)
            3'b000: f_d = ALU_A & b_q;
            3'b001: f_d = ALU_A | b_q;
            3'b010: f_d = ALU_A ^ b_q;
            3'b011: f_d = ~(ALU_A | b_q);
            3'b100, 3'b101: begin
                f_d  = sum;
                of_d = (ALU_A[M] == (b_q[M] ^ op_q[0])) && (sum[M] != ALU_A[M]);
            end
            3'b110: f_d = DATA_W'($signed(ALU_A) < $signed(b_q));
            default: f_d = b_q << ALU_A[SW-1:0];
        endcase
    end

    always_comb begin
        state_d = HALT;
        case (state_q)
            FETCH:   state_d = DECODE;
            DECODE:  state_d = legal ? EXEC : HALT;
            EXEC:    state_d = WB;
            WB:      state_d = FETCH;
            default: state_d = HALT;
        endcase
    end

    always_ff @(posedge clk) state_q <= rst ? FETCH : state_d;

    always_ff @(posedge clk) if (rst && imem_we) imem[imem_addr] <= imem_wdata;

    // r0 is reset to zero and never written, so reads of it need no special case
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q      <= '0;
            ir_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            f_q       <= '0;
            op_q      <= '0;
            sh_q      <= 1'b0;
            zf_q      <= 1'b0;
            of_q      <= 1'b0;
            instret_q <= '0;
            for (int i = 0; i < 32; i++) regs_q[i] <= REG_INIT_IDX != 0 ? DATA_W'(i) : '0;
        end else begin
            if (state_q == FETCH) ir_q <= imem[pc_q];
            if (state_q == DECODE && legal) begin
                a_q  <= regs_q[ir_q[25:21]];
                b_q  <= regs_q[ir_q[20:16]];
                op_q <= op_d;
                sh_q <= sh_d;
            end
            if (state_q == EXEC) begin
                f_q  <= f_d;
                zf_q <= f_d == '0;
                of_q <= of_d;
            end
            if (state_q == WB) begin
                if (ir_q[15:11] != 5'd0) regs_q[ir_q[15:11]] <= f_q;
                pc_q      <= pc_q + AW'(1);
                instret_q <= instret_q + 32'd1;
            end
        end
    end

    assign Inst_code = ir_q;
    assign PC        = 32'({pc_q, 2'b00});
    assign {opcode, rs, rt, rd, shamt, func} = ir_q;
    assign ALU_OP    = op_q;
    assign rs_shamt  = sh_q;
    assign ALU_F     = f_q;
    assign FR_ZF     = zf_q;
    assign FR_OF     = of_q;
    assign state     = state_q;
    assign halted    = state_q == HALT;
    assign instret   = instret_q;
endmodule
